// File: rtl/mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mul_arbiter
//  Description : Round-robin arbiter sharing one Montgomery field multiplier
//                between NREQ requester FSMs. Each requester keeps its own
//                A/B/op/rst_mul/done_mul handshake; the arbiter muxes operands
//                and the multiplier reset, holds the result and steers done
//                only to the granted requester.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1       system clock, posedge
//    rst          in   1       synchronous reset, active-low
//    req_A/req_B  in   NREQ*N  requester operands, slice i = [i*N +: N]
//    req_op       in   NREQ*2  requester op codes, slice i = [i*2 +: 2]
//    req_rst_mul  in   NREQ    0 = requesting, 1 = idle/release
//    req_done     out  NREQ    per-requester done (granted bit only)
//    req_mul      out  N       held result, broadcast
//    mul_A/mul_B  out  N       operands to multiplier (combinational mux)
//    mul_op       out  2       op code to multiplier (combinational mux)
//    mul_rst      out  1       multiplier reset, active-high
//    mul_done     in   1       multiplier done
//    mul_out      in   N       multiplier result
//    grant_idx    out  IDX_W   current / last granted requester
//    busy         out  1       high in BUSY or HOLD
// ============================================================================
module mul_arbiter #(
  parameter int N     = 512,
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ*N-1:0]   req_A,
  input  logic [NREQ*N-1:0]   req_B,
  input  logic [NREQ*2-1:0]   req_op,
  input  logic [NREQ-1:0]     req_rst_mul,
  output logic [NREQ-1:0]     req_done,
  output logic [N-1:0]        req_mul,
  output logic [N-1:0]        mul_A,
  output logic [N-1:0]        mul_B,
  output logic [1:0]          mul_op,
  output logic                mul_rst,
  input  logic                mul_done,
  input  logic [N-1:0]        mul_out,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Last-grant pointer resets to NREQ-1 so requester 0 wins first.
  localparam logic [IDX_W-1:0] c_LAST_RST = IDX_W'(NREQ - 1);

  state_t            r_state,   w_state;
  logic [IDX_W-1:0]  r_grant,   w_grant;
  logic [IDX_W-1:0]  r_last,    w_last;
  logic [NREQ-1:0]   r_done,    w_done;
  logic [N-1:0]      r_mul,     w_mul;
  logic              r_mul_rst, w_mul_rst;
  logic              r_busy,    w_busy;

  logic              w_any;
  logic [IDX_W-1:0]  w_pick;

  // Round-robin pick: scan last+1, last+2, ... (mod NREQ). The loop runs from
  // the farthest candidate to the nearest so the nearest pending one wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (!req_rst_mul[(int'(r_last) + k) % NREQ]) begin
        w_any  = 1'b1;
        w_pick = IDX_W'((int'(r_last) + k) % NREQ);
      end
    end
  end

  // Operand path is a pure mux on the registered grant; requesters hold
  // their operands stable, so no capture register is needed.
  assign mul_A  = req_A[int'(r_grant)*N +: N];
  assign mul_B  = req_B[int'(r_grant)*N +: N];
  assign mul_op = req_op[int'(r_grant)*2 +: 2];

  // Next-state and next-output logic
  always_comb begin
    w_state   = r_state;
    w_grant   = r_grant;
    w_last    = r_last;
    w_done    = r_done;
    w_mul     = r_mul;
    w_mul_rst = r_mul_rst;
    w_busy    = r_busy;

    case (r_state)
      S_IDLE: begin
        w_mul_rst = 1'b1;
        w_done    = '0;
        w_busy    = 1'b0;
        if (w_any) begin
          w_grant   = w_pick;
          w_last    = w_pick;
          w_mul_rst = 1'b0;
          w_busy    = 1'b1;
          w_state   = S_BUSY;
        end
      end

      S_BUSY: begin
        w_mul_rst = 1'b0;
        // Abort takes priority over a coincident mul_done.
        if (req_rst_mul[r_grant]) begin
          w_mul_rst = 1'b1;
          w_busy    = 1'b0;
          w_state   = S_IDLE;
        end else if (mul_done) begin
          w_mul              = mul_out;
          w_done             = '0;
          w_done[r_grant]    = 1'b1;
          w_mul_rst          = 1'b1;
          w_state            = S_HOLD;
        end
      end

      S_HOLD: begin
        // Multiplier already cleared; done and result stay put until the
        // granted requester releases by raising its rst_mul.
        w_mul_rst = 1'b1;
        if (req_rst_mul[r_grant]) begin
          w_done  = '0;
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end
      end

      default: begin
        w_state   = S_IDLE;
        w_mul_rst = 1'b1;
        w_done    = '0;
        w_busy    = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_last    <= c_LAST_RST;
      r_done    <= '0;
      r_mul     <= '0;
      r_mul_rst <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_grant   <= w_grant;
      r_last    <= w_last;
      r_done    <= w_done;
      r_mul     <= w_mul;
      r_mul_rst <= w_mul_rst;
      r_busy    <= w_busy;
    end
  end

  assign req_done  = r_done;
  assign req_mul   = r_mul;
  assign mul_rst   = r_mul_rst;
  assign grant_idx = r_grant;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_arbiter
//  Description : Directed self-checking bench for mul_arbiter with a mock
//                multiplier (done four cycles after mul_rst falls, result
//                A+B held until mul_rst rises).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_arbiter;

  localparam int N     = 16;
  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  logic                clk;
  logic                rst;
  logic [NREQ*N-1:0]   req_A;
  logic [NREQ*N-1:0]   req_B;
  logic [NREQ*2-1:0]   req_op;
  logic [NREQ-1:0]     req_rst_mul;
  logic [NREQ-1:0]     req_done;
  logic [N-1:0]        req_mul;
  logic [N-1:0]        mul_A;
  logic [N-1:0]        mul_B;
  logic [1:0]          mul_op;
  logic                mul_rst;
  logic                mul_done;
  logic [N-1:0]        mul_out;
  logic [IDX_W-1:0]    grant_idx;
  logic                busy;

  int checks   = 0;
  int failures = 0;

  mul_arbiter #(.N(N), .NREQ(NREQ), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_A      (req_A),
    .req_B      (req_B),
    .req_op     (req_op),
    .req_rst_mul(req_rst_mul),
    .req_done   (req_done),
    .req_mul    (req_mul),
    .mul_A      (mul_A),
    .mul_B      (mul_B),
    .mul_op     (mul_op),
    .mul_rst    (mul_rst),
    .mul_done   (mul_done),
    .mul_out    (mul_out),
    .grant_idx  (grant_idx),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mock multiplier
  int r_cnt;
  always @(posedge clk) begin
    if (mul_rst) begin
      r_cnt    <= 0;
      mul_done <= 1'b0;
    end else if (r_cnt == 3) begin
      mul_done <= 1'b1;
      mul_out  <= mul_A + mul_B;
    end else begin
      r_cnt <= r_cnt + 1;
    end
  end
  initial mul_out = '0;

  // Grant monitor: log each mul_rst falling edge with grant index and the
  // number of cycles mul_rst was high beforehand.
  int   grant_log [0:63];
  int   gap_log   [0:63];
  int   n_grants = 0;
  int   hi_run   = 0;
  logic prev_rst = 1'b1;
  always @(posedge clk) begin
    prev_rst <= mul_rst;
    if (mul_rst) begin
      hi_run <= hi_run + 1;
    end else begin
      hi_run <= 0;
      if (prev_rst && n_grants < 64) begin
        grant_log[n_grants] <= int'(grant_idx);
        gap_log[n_grants]   <= hi_run;
        n_grants            <= n_grants + 1;
      end
    end
  end

  task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [1:0] op);
    req_A[i*N +: N]  = a;
    req_B[i*N +: N]  = b;
    req_op[i*2 +: 2] = op;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_done !== '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_rst_mul = '1;
    req_A = '0; req_B = '0; req_op = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (mul_rst !== 1'b1 || req_done !== 4'b0000 || req_mul !== 16'd0 ||
        grant_idx !== 2'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset: mul_rst=%b done=%b mul=%0d grant=%0d busy=%b required 1 0000 0 0 0",
               mul_rst, req_done, req_mul, grant_idx, busy);
    end
    rst = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    @(negedge clk);
    set_req(1, 16'd3, 16'd5, 2'b01);
    req_rst_mul[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (mul_rst !== 1'b0 || grant_idx !== 2'd1 || busy !== 1'b1 ||
        mul_A !== 16'd3 || mul_B !== 16'd5 || mul_op !== 2'b01) begin
      failures++;
      $display("FAIL single_grant: mul_rst=%b grant=%0d busy=%b A=%0d B=%0d op=%0d required 0 1 1 3 5 1",
               mul_rst, grant_idx, busy, mul_A, mul_B, mul_op);
    end
    wait_done(ok);
    checks++;
    if (!ok || req_done !== 4'b0010 || req_mul !== 16'd8 || mul_rst !== 1'b1) begin
      failures++;
      $display("FAIL single_done: ok=%b done=%b mul=%0d mul_rst=%b required 1 0010 8 1",
               ok, req_done, req_mul, mul_rst);
    end
    req_rst_mul[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (req_done !== 4'b0000 || busy !== 1'b0 || req_mul !== 16'd8) begin
      failures++;
      $display("FAIL single_release: done=%b busy=%b mul=%0d required 0000 0 8",
               req_done, busy, req_mul);
    end
  endtask

  task automatic test_contention();
    bit ok;
    int start;
    do_reset();
    start = n_grants;
    set_req(0, 16'd10, 16'd1, 2'b00);
    set_req(2, 16'd7,  16'd7, 2'b00);
    req_rst_mul[0] = 1'b0;
    req_rst_mul[2] = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok || req_done !== 4'b0001 || req_mul !== 16'd11) begin
      failures++;
      $display("FAIL contention_first: ok=%b done=%b mul=%0d required 1 0001 11", ok, req_done, req_mul);
    end
    req_rst_mul[0] = 1'b1;
    wait_done(ok);
    checks++;
    if (!ok || req_done !== 4'b0100 || req_mul !== 16'd14) begin
      failures++;
      $display("FAIL contention_second: ok=%b done=%b mul=%0d required 1 0100 14", ok, req_done, req_mul);
    end
    req_rst_mul[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (n_grants - start !== 2 || grant_log[start] !== 0 || grant_log[start+1] !== 2 ||
        gap_log[start+1] < 2) begin
      failures++;
      $display("FAIL contention_order: grants=%0d first=%0d second=%0d gap=%0d required 2 0 2 >=2",
               n_grants - start, grant_log[start], grant_log[start+1], gap_log[start+1]);
    end
  endtask

  task automatic test_fairness();
    bit ok;
    int start;
    int bad;
    do_reset();
    start = n_grants;
    bad = 0;
    for (int i = 0; i < NREQ; i++) set_req(i, 16'(100 + i), 16'(i), 2'b00);
    req_rst_mul = '0;
    for (int k = 0; k < 8; k++) begin
      int exp_i;
      exp_i = k % NREQ;
      wait_done(ok);
      checks++;
      if (!ok || req_done !== NREQ'(1 << exp_i) || req_mul !== 16'(100 + 2*exp_i)) begin
        failures++;
        $display("FAIL fairness_op%0d: ok=%b done=%b mul=%0d required 1 %b %0d",
                 k, ok, req_done, req_mul, NREQ'(1 << exp_i), 100 + 2*exp_i);
      end
      req_rst_mul[exp_i] = 1'b1;
      @(negedge clk);
      req_rst_mul[exp_i] = 1'b0;
    end
    req_rst_mul = '1;
    repeat (2) @(negedge clk);
    for (int k = 1; k < 8; k++) if (gap_log[start+k] < 2) bad++;
    checks++;
    if (n_grants - start < 8 || bad != 0) begin
      failures++;
      $display("FAIL fairness_gap: grants=%0d short_gaps=%0d required >=8 0", n_grants - start, bad);
    end
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    set_req(3, 16'd40, 16'd2, 2'b11);
    req_rst_mul[3] = 1'b0;
    @(negedge clk);
    checks++;
    if (mul_rst !== 1'b0 || grant_idx !== 2'd3 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_grant: mul_rst=%b grant=%0d busy=%b required 0 3 1", mul_rst, grant_idx, busy);
    end
    @(negedge clk);
    req_rst_mul[3] = 1'b1;
    @(negedge clk);
    checks++;
    if (mul_rst !== 1'b1 || busy !== 1'b0 || req_done !== 4'b0000) begin
      failures++;
      $display("FAIL abort_idle: mul_rst=%b busy=%b done=%b required 1 0 0000", mul_rst, busy, req_done);
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (req_done !== 4'b0000) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_nodone: cycles_with_done=%0d required 0", seen);
    end
  endtask

  task automatic test_reset_midop();
    bit ok;
    @(negedge clk);
    set_req(2, 16'd9, 16'd9, 2'b00);
    req_rst_mul[2] = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || grant_idx !== 2'd2) begin
      failures++;
      $display("FAIL midop_busy: busy=%b grant=%0d required 1 2", busy, grant_idx);
    end
    rst = 1'b0;
    set_req(0, 16'd1, 16'd2, 2'b00);
    req_rst_mul[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (mul_rst !== 1'b1 || req_done !== 4'b0000 || busy !== 1'b0 || grant_idx !== 2'd0) begin
      failures++;
      $display("FAIL midop_reset: mul_rst=%b done=%b busy=%b grant=%0d required 1 0000 0 0",
               mul_rst, req_done, busy, grant_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (mul_rst !== 1'b0 || grant_idx !== 2'd0) begin
      failures++;
      $display("FAIL midop_regrant: mul_rst=%b grant=%0d required 0 0", mul_rst, grant_idx);
    end
    wait_done(ok);
    checks++;
    if (!ok || req_done !== 4'b0001 || req_mul !== 16'd3) begin
      failures++;
      $display("FAIL midop_done: ok=%b done=%b mul=%0d required 1 0001 3", ok, req_done, req_mul);
    end
    req_rst_mul = '1;
    do_reset();
  endtask

  task automatic test_isolation();
    bit ok;
    int bad;
    bad = 0;
    @(negedge clk);
    set_req(0, 16'd20, 16'd30, 2'b10);
    set_req(1, 16'd1,  16'd1,  2'b01);
    req_rst_mul[0] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      set_req(1, 16'(500 + k), 16'(700 + k), 2'b01);
      #1;
      if (mul_A !== 16'd20 || mul_B !== 16'd30 || mul_op !== 2'b10) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL isolation_operands: bad_samples=%0d A=%0d B=%0d op=%0d required 0 20 30 2",
               bad, mul_A, mul_B, mul_op);
    end
    wait_done(ok);
    checks++;
    if (!ok || req_done !== 4'b0001 || req_mul !== 16'd50) begin
      failures++;
      $display("FAIL isolation_done: ok=%b done=%b mul=%0d required 1 0001 50", ok, req_done, req_mul);
    end
    req_rst_mul[0] = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    req_rst_mul = '1;
    req_A = '0; req_B = '0; req_op = '0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_abort();
    test_reset_midop();
    test_isolation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
